// File: rtl/axi4_byte_en_sram.sv
// AXI4 slave bridge in front of a single-port, byte-enabled synchronous SRAM.
// Serves one burst at a time; each beat is a single full-width SRAM access.
module axi4_byte_en_sram #(
    parameter int MEM_ADDR_BITS     = 10,
    parameter int AXI_ADDRESS_WIDTH = 32,
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int AXI_ID_WIDTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [AXI_ID_WIDTH-1:0]       AWID,
    input  logic [AXI_ADDRESS_WIDTH-1:0]  AWADDR,
    input  logic [7:0]                    AWLEN,
    input  logic [2:0]                    AWSIZE,
    input  logic [1:0]                    AWBURST,
    input  logic                          AWVALID,
    output logic                          AWREADY,

    input  logic [AXI_DATA_WIDTH-1:0]     WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                          WLAST,
    input  logic                          WVALID,
    output logic                          WREADY,

    output logic [AXI_ID_WIDTH-1:0]       BID,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,

    input  logic [AXI_ID_WIDTH-1:0]       ARID,
    input  logic [AXI_ADDRESS_WIDTH-1:0]  ARADDR,
    input  logic [7:0]                    ARLEN,
    input  logic [2:0]                    ARSIZE,
    input  logic [1:0]                    ARBURST,
    input  logic                          ARVALID,
    output logic                          ARREADY,

    output logic [AXI_ID_WIDTH-1:0]       RID,
    output logic [AXI_DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RLAST,
    output logic                          RVALID,
    input  logic                          RREADY
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int DEPTH  = 1 << MEM_ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        WRESP   = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       last_write;
    logic [AXI_ID_WIDTH-1:0]    wr_id;
    logic [AXI_ID_WIDTH-1:0]    rd_id;
    logic [MEM_ADDR_BITS-1:0]   addr;
    logic [7:0]                 len;
    logic [7:0]                 cnt;
    logic                       fixed;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q;
    logic [AXI_DATA_WIDTH-1:0]  mem [DEPTH];

    logic pick_write;
    logic pick_read;
    logic aw_hs;
    logic ar_hs;
    logic w_hs;
    logic r_hs;
    logic last_beat;

    // Size, WLAST and the address bits outside the word index play no role.
    logic unused_inputs;
    assign unused_inputs = ^{AWSIZE, ARSIZE, WLAST, AWADDR, ARADDR};

    // Valid/ready: a transfer happens on a rising edge where both are high;
    // a raised VALID is held, with its payload stable, until that transfer.
    always_comb begin
        pick_write = AWVALID && (!ARVALID || !last_write);
        pick_read  = ARVALID && (!AWVALID || last_write);

        AWREADY = !rst && (state == IDLE) && pick_write;
        ARREADY = !rst && (state == IDLE) && pick_read;
        WREADY  = !rst && (state == WRITE);
        BVALID  = !rst && (state == WRESP);
        RVALID  = !rst && (state == RD_DATA);

        aw_hs     = AWVALID && AWREADY;
        ar_hs     = ARVALID && ARREADY;
        w_hs      = WVALID && WREADY;
        r_hs      = RVALID && RREADY;
        last_beat = (cnt == len);

        RLAST = RVALID && last_beat;
        BID   = wr_id;
        RID   = rd_id;
        RDATA = rdata_q;
        BRESP = 2'b00;
        RRESP = 2'b00;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (aw_hs) begin
                    state_next = WRITE;
                end else if (ar_hs) begin
                    state_next = RD_ADDR;
                end
            end
            WRITE: begin
                if (w_hs && last_beat) begin
                    state_next = WRESP;
                end
            end
            WRESP: begin
                if (BREADY) begin
                    state_next = IDLE;
                end
            end
            RD_ADDR: state_next = RD_DATA;
            RD_DATA: begin
                if (r_hs) begin
                    state_next = last_beat ? IDLE : RD_ADDR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_write <= 1'b0;
            wr_id      <= '0;
            rd_id      <= '0;
            addr       <= '0;
            len        <= '0;
            cnt        <= '0;
            fixed      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state <= state_next;
            if (aw_hs) begin
                wr_id      <= AWID;
                addr       <= AWADDR[SHIFT +: MEM_ADDR_BITS];
                len        <= AWLEN;
                cnt        <= '0;
                fixed      <= (AWBURST == 2'b00);
                last_write <= 1'b1;
            end else if (ar_hs) begin
                rd_id      <= ARID;
                addr       <= ARADDR[SHIFT +: MEM_ADDR_BITS];
                len        <= ARLEN;
                cnt        <= '0;
                fixed      <= (ARBURST == 2'b00);
                last_write <= 1'b0;
            end
            // INCR and WRAP both step one word; the address width gives the wrap.
            if (w_hs || r_hs) begin
                cnt <= cnt + 8'd1;
                if (!fixed) begin
                    addr <= addr + 1'b1;
                end
            end
            if (state == RD_ADDR) begin
                rdata_q <= mem[addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (WSTRB[i]) begin
                    mem[addr][i*8 +: 8] <= WDATA[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_byte_en_sram.sv
// Bench for axi4_byte_en_sram: directed AXI scenarios plus random bursts,
// checked against a word-array model of the memory.
module tb_axi4_byte_en_sram;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    axi4_byte_en_sram #(
        .MEM_ADDR_BITS(10), .AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] wdata_q [$];
    logic [3:0]  wstrb_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Word touched by a given beat: FIXED stays put, INCR/WRAP step and wrap at the depth.
    function automatic int word_of(input logic [31:0] addr, input int beat, input logic [1:0] burst);
        int base;
        base = int'((addr / 32'd4) % DEPTH);
        if (burst == 2'b00) return base;
        return (base + beat) % DEPTH;
    endfunction

    task automatic load_beats(input int n, input bit rand_strb);
        wdata_q.delete();
        wstrb_q.delete();
        for (int i = 0; i < n; i++) begin
            wdata_q.push_back($urandom);
            wstrb_q.push_back(rand_strb ? 4'($urandom_range(0, 15)) : 4'hF);
        end
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        int n;
        AWID = id; AWADDR = addr; AWLEN = 8'(len); AWBURST = burst; AWSIZE = 3'd2; AWVALID = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!AWREADY && n < 50);
        check("aw_accept", AWREADY, 1);
        @(posedge clk); #1;
        AWVALID = 1'b0;
    endtask

    task automatic w_phase(input logic [31:0] addr, input logic [1:0] burst, input int nbeats, input bit gaps);
        int w;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps) begin
                WVALID = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            WDATA = wdata_q[b]; WSTRB = wstrb_q[b]; WLAST = 1'($urandom_range(0, 1)); WVALID = 1'b1;
            @(negedge clk);
            check("w_ready", WREADY, 1);
            @(posedge clk); #1;
            w = word_of(addr, b, burst);
            for (int i = 0; i < 4; i++)
                if (wstrb_q[b][i]) model[w][i*8 +: 8] = wdata_q[b][i*8 +: 8];
        end
        WVALID = 1'b0;
        WLAST = 1'b0;
    endtask

    task automatic b_phase(input logic [3:0] exp_id, input int delay);
        int n;
        BREADY = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!BVALID && n < 20);
        check("b_latency", n, 1);
        check("b_id", BID, exp_id);
        check("b_resp", BRESP, 0);
        repeat (delay) begin
            @(negedge clk);
            check("b_hold_valid", BVALID, 1);
            check("b_hold_id", BID, exp_id);
        end
        BREADY = 1'b1;
        @(posedge clk); #1;
        BREADY = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input bit gaps, input int bdelay);
        aw_phase(id, addr, len, burst);
        w_phase(addr, burst, len + 1, gaps);
        b_phase(id, bdelay);
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        int n;
        ARID = id; ARADDR = addr; ARLEN = 8'(len); ARBURST = burst; ARSIZE = 3'd2; ARVALID = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ARREADY && n < 50);
        check("ar_accept", ARREADY, 1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
    endtask

    // stall < 0 picks a random RREADY hold-off of 0..2 cycles per beat.
    task automatic r_phase(input logic [3:0] exp_id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int stall);
        int n;
        int s;
        logic [31:0] exp;
        RREADY = 1'b1;
        for (int b = 0; b <= len; b++) begin
            exp = model[word_of(addr, b, burst)];
            n = 0;
            do begin @(negedge clk); n++; end while (!RVALID && n < 20);
            check("r_latency", n, 2);
            check("r_data", RDATA, exp);
            check("r_last", RLAST, (b == len));
            check("r_id", RID, exp_id);
            check("r_resp", RRESP, 0);
            s = (stall < 0) ? $urandom_range(0, 2) : stall;
            if (s > 0) begin
                RREADY = 1'b0;
                repeat (s) begin
                    @(negedge clk);
                    check("r_hold_valid", RVALID, 1);
                    check("r_hold_data", RDATA, exp);
                end
                RREADY = 1'b1;
            end
            @(posedge clk);
        end
        #1;
        RREADY = 1'b0;
    endtask

    initial begin
        int          len;
        logic [1:0]  burst;
        logic [31:0] addr;
        logic [3:0]  id;

        rst = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rlast", RLAST, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_rresp", RRESP, 0);
        check("rst_bid", BID, 0);
        check("rst_rid", RID, 0);
        check("rst_rdata", RDATA, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention straight out of reset: write wins, the pending read follows.
        load_beats(1, 1'b0);
        ARID = 4'h9; ARADDR = 32'h40; ARLEN = 8'd0; ARBURST = 2'b01; ARSIZE = 3'd2; ARVALID = 1'b1;
        AWID = 4'h3; AWADDR = 32'h40; AWLEN = 8'd0; AWBURST = 2'b01; AWSIZE = 3'd2; AWVALID = 1'b1;
        @(negedge clk);
        check("cont_awready", AWREADY, 1);
        check("cont_arready", ARREADY, 0);
        @(posedge clk); #1;
        AWVALID = 1'b0;
        w_phase(32'h40, 2'b01, 1, 1'b0);
        b_phase(4'h3, 0);
        @(negedge clk);
        check("cont_read_next", ARREADY, 1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        r_phase(4'h9, 32'h40, 0, 2'b01, 0);

        // Fill the whole array so every later read has a known expectation.
        for (int k = 0; k < 4; k++) begin
            load_beats(256, 1'b0);
            do_write(4'(k), 32'(k * 1024), 255, 2'b01, 1'b0, 0);
        end

        // Single full-width write and read-back.
        wdata_q = '{32'hDEADBEEF}; wstrb_q = '{4'hF};
        do_write(4'h5, 32'h10, 0, 2'b01, 1'b0, 0);
        ar_phase(4'h6, 32'h10, 0, 2'b01);
        r_phase(4'h6, 32'h10, 0, 2'b01, 0);

        // Partial strobe merges into the existing word.
        wdata_q = '{32'h11223344}; wstrb_q = '{4'hF};
        do_write(4'h1, 32'h20, 0, 2'b01, 1'b0, 0);
        wdata_q = '{32'hAABBCCDD}; wstrb_q = '{4'h5};
        do_write(4'h2, 32'h20, 0, 2'b01, 1'b0, 0);
        ar_phase(4'h7, 32'h20, 0, 2'b01);
        r_phase(4'h7, 32'h20, 0, 2'b01, 0);
        check("strobe_merge", RDATA, 32'h11BB33DD);

        // INCR burst of four back-to-back beats, then INCR and FIXED reads.
        wdata_q = '{32'd1, 32'd2, 32'd3, 32'd4}; wstrb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4'hA, 32'h100, 3, 2'b01, 1'b0, 0);
        ar_phase(4'hB, 32'h100, 3, 2'b01);
        r_phase(4'hB, 32'h100, 3, 2'b01, 0);
        ar_phase(4'hC, 32'h100, 3, 2'b00);
        r_phase(4'hC, 32'h100, 3, 2'b00, 0);
        check("fixed_last_beat", RDATA, 32'd1);

        // Backpressure on both response channels.
        load_beats(2, 1'b0);
        do_write(4'hD, 32'h180, 1, 2'b01, 1'b0, 3);
        ar_phase(4'hE, 32'h100, 3, 2'b01);
        r_phase(4'hE, 32'h100, 3, 2'b01, 5);

        // Upper address bits alias: word 1024 lands on word 0.
        wdata_q = '{32'hA5A5A5A5}; wstrb_q = '{4'hF};
        do_write(4'h4, 32'h1000, 0, 2'b01, 1'b0, 0);
        ar_phase(4'h8, 32'h0, 0, 2'b01);
        r_phase(4'h8, 32'h0, 0, 2'b01, 0);
        check("alias_word0", RDATA, 32'hA5A5A5A5);

        // Burst crossing the top of memory wraps to word 0.
        load_beats(4, 1'b0);
        do_write(4'h2, 32'hFF8, 3, 2'b10, 1'b0, 0);
        ar_phase(4'h3, 32'hFF8, 3, 2'b01);
        r_phase(4'h3, 32'hFF8, 3, 2'b01, 0);

        // Reset in the middle of a write burst keeps only the beats already taken.
        load_beats(4, 1'b0);
        aw_phase(4'h6, 32'h200, 3, 2'b01);
        w_phase(32'h200, 2'b01, 2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_wready", WREADY, 0);
        check("midrst_bvalid", BVALID, 0);
        check("midrst_bid", BID, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ar_phase(4'h7, 32'h200, 3, 2'b01);
        r_phase(4'h7, 32'h200, 3, 2'b01, 0);

        // Random bursts: write, read the same region back, then an unrelated read.
        for (int it = 0; it < 25; it++) begin
            len   = (it % 5 == 4) ? $urandom_range(8, 20) : $urandom_range(0, 7);
            burst = 2'($urandom_range(0, 2));
            addr  = $urandom;
            id    = 4'($urandom_range(0, 15));
            load_beats(len + 1, 1'b1);
            do_write(id, addr, len, burst, 1'b1, $urandom_range(0, 2));
            ar_phase(~id, addr, len, burst);
            r_phase(~id, addr, len, burst, -1);
            len   = $urandom_range(0, 5);
            burst = 2'($urandom_range(0, 2));
            addr  = $urandom;
            ar_phase(id, addr, len, burst);
            r_phase(id, addr, len, burst, -1);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
